// File: rtl/ceespu_hazard_ctrl.sv
// Hazard sequencer for the fetch/decode/execute pipeline: multi-cycle stalls,
// load-use bubbles, post-branch flushes and a saturating stall-cycle counter.
module ceespu_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_dec_valid,
  input  logic [4:0]       I_dec_selA,
  input  logic [4:0]       I_dec_selB,
  input  logic             I_dec_useA,
  input  logic             I_dec_useB,
  input  logic [4:0]       I_ex_selD,
  input  logic             I_ex_we,
  input  logic             I_ex_isLoad,
  input  logic             I_ex_busy,
  input  logic             I_ex_branch,
  input  logic             I_cnt_clr,
  output logic             O_stall_fetch,
  output logic             O_stall_decode,
  output logic             O_bubble,
  output logic             O_flush,
  output logic [1:0]       O_state,
  output logic [CNT_W-1:0] O_stall_count
);

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_MC_WAIT     = 2'd1;
  localparam logic [1:0] ST_FLUSH       = 2'd2;
  localparam logic [1:0] ST_LOAD_BUBBLE = 2'd3;
  localparam logic [2:0] FLUSH_INIT     = 3'(FLUSH_CYCLES - 1);
  localparam logic       MULTI_FLUSH    = (FLUSH_CYCLES > 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [2:0]       flush_cnt;
  logic [2:0]       flush_cnt_next;
  logic [CNT_W-1:0] stall_count;
  logic             load_use;
  logic             stall_fetch;
  logic             stall_decode;
  logic             bubble;
  logic             flush;

  // Register 0 is hardwired, so a load targeting it can never create a hazard
  assign load_use = I_dec_valid & I_ex_isLoad & I_ex_we & (I_ex_selD != 5'd0) &
                    ((I_dec_useA & (I_dec_selA == I_ex_selD)) |
                     (I_dec_useB & (I_dec_selB == I_ex_selD)));

  // Next-state and raw hazard outputs
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    bubble         = 1'b0;
    flush          = 1'b0;
    case (state)
      ST_RUN: begin
        if (I_ex_branch) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (MULTI_FLUSH) begin
            state_next     = ST_FLUSH;
            flush_cnt_next = FLUSH_INIT;
          end else begin
            state_next = ST_RUN;
          end
        end else if (I_ex_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          state_next   = ST_MC_WAIT;
        end else if (load_use) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          bubble       = 1'b1;
          state_next   = ST_LOAD_BUBBLE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_MC_WAIT: begin
        if (I_ex_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush          = 1'b1;
        bubble         = 1'b1;
        flush_cnt_next = flush_cnt - 3'd1;
        if (flush_cnt == 3'd1) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_FLUSH;
        end
      end
      ST_LOAD_BUBBLE: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next     = ST_RUN;
        flush_cnt_next = 3'd0;
      end
    endcase
  end

  // Outputs are held low for the whole time reset is asserted
  assign O_stall_fetch  = I_rst & stall_fetch;
  assign O_stall_decode = I_rst & stall_decode;
  assign O_bubble       = I_rst & bubble;
  assign O_flush        = I_rst & flush;
  assign O_state        = state;
  assign O_stall_count  = stall_count;

  // State and flush down-counter
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (I_cnt_clr) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (O_stall_decode && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_ceespu_hazard_ctrl.sv
// Directed bench for ceespu_hazard_ctrl: vector table plus hand-written
// sequences for flush length, counter saturation and reset abort.
module tb_ceespu_hazard_ctrl;

  logic       I_clk = 1'b0;
  logic       I_rst;
  logic       I_dec_valid, I_dec_useA, I_dec_useB;
  logic [4:0] I_dec_selA, I_dec_selB, I_ex_selD;
  logic       I_ex_we, I_ex_isLoad, I_ex_busy, I_ex_branch, I_cnt_clr;

  logic        sf0, sd0, bub0, fl0;
  logic [1:0]  st0;
  logic [3:0]  cnt0;
  logic        sf1, sd1, bub1, fl1;
  logic [1:0]  st1;
  logic [15:0] cnt1;
  logic        sf3, sd3, bub3, fl3;
  logic [1:0]  st3;
  logic [15:0] cnt3;

  int tests = 0;
  int fails = 0;

  always #5 I_clk = ~I_clk;

  ceespu_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_dec_valid(I_dec_valid),
    .I_dec_selA(I_dec_selA), .I_dec_selB(I_dec_selB),
    .I_dec_useA(I_dec_useA), .I_dec_useB(I_dec_useB),
    .I_ex_selD(I_ex_selD), .I_ex_we(I_ex_we), .I_ex_isLoad(I_ex_isLoad),
    .I_ex_busy(I_ex_busy), .I_ex_branch(I_ex_branch), .I_cnt_clr(I_cnt_clr),
    .O_stall_fetch(sf0), .O_stall_decode(sd0), .O_bubble(bub0),
    .O_flush(fl0), .O_state(st0), .O_stall_count(cnt0));

  ceespu_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut1 (
    .I_clk(I_clk), .I_rst(I_rst), .I_dec_valid(I_dec_valid),
    .I_dec_selA(I_dec_selA), .I_dec_selB(I_dec_selB),
    .I_dec_useA(I_dec_useA), .I_dec_useB(I_dec_useB),
    .I_ex_selD(I_ex_selD), .I_ex_we(I_ex_we), .I_ex_isLoad(I_ex_isLoad),
    .I_ex_busy(I_ex_busy), .I_ex_branch(I_ex_branch), .I_cnt_clr(I_cnt_clr),
    .O_stall_fetch(sf1), .O_stall_decode(sd1), .O_bubble(bub1),
    .O_flush(fl1), .O_state(st1), .O_stall_count(cnt1));

  ceespu_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut3 (
    .I_clk(I_clk), .I_rst(I_rst), .I_dec_valid(I_dec_valid),
    .I_dec_selA(I_dec_selA), .I_dec_selB(I_dec_selB),
    .I_dec_useA(I_dec_useA), .I_dec_useB(I_dec_useB),
    .I_ex_selD(I_ex_selD), .I_ex_we(I_ex_we), .I_ex_isLoad(I_ex_isLoad),
    .I_ex_busy(I_ex_busy), .I_ex_branch(I_ex_branch), .I_cnt_clr(I_cnt_clr),
    .O_stall_fetch(sf3), .O_stall_decode(sd3), .O_bubble(bub3),
    .O_flush(fl3), .O_state(st3), .O_stall_count(cnt3));

  typedef struct {
    logic       v, ua, ub;
    logic [4:0] sa, sb, sd;
    logic       we, ld, busy, br;
    logic       e_sf, e_sd, e_bub, e_fl;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic v, ua, ub, input logic [4:0] sa, sb, sd,
                              input logic we, ld, busy, br,
                              input logic e_sf, e_sd, e_bub, e_fl, input logic [1:0] e_st);
    vec_t r;
    r.v = v; r.ua = ua; r.ub = ub; r.sa = sa; r.sb = sb; r.sd = sd;
    r.we = we; r.ld = ld; r.busy = busy; r.br = br;
    r.e_sf = e_sf; r.e_sd = e_sd; r.e_bub = e_bub; r.e_fl = e_fl; r.e_st = e_st;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    I_dec_valid = 1'b0; I_dec_useA = 1'b0; I_dec_useB = 1'b0;
    I_dec_selA = 5'd0; I_dec_selB = 5'd0; I_ex_selD = 5'd0;
    I_ex_we = 1'b0; I_ex_isLoad = 1'b0; I_ex_busy = 1'b0;
    I_ex_branch = 1'b0; I_cnt_clr = 1'b0;
  endtask

  task automatic check_main(input string name, input logic sf, sd, bub, fl, input logic [1:0] st);
    check({name, ".stall_fetch"}, {31'd0, sf0}, {31'd0, sf});
    check({name, ".stall_decode"}, {31'd0, sd0}, {31'd0, sd});
    check({name, ".bubble"}, {31'd0, bub0}, {31'd0, bub});
    check({name, ".flush"}, {31'd0, fl0}, {31'd0, fl});
    check({name, ".state"}, {30'd0, st0}, {30'd0, st});
  endtask

  initial begin
    // Load-use, register-0, qualifier and priority/flush/busy sequence
    vecs[0]  = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, 0,0,0,0, 2'd0);
    vecs[1]  = mk(1,0,1, 5'd0,5'd5,5'd5, 1,1,0,0, 1,1,1,0, 2'd0);
    vecs[2]  = mk(1,0,1, 5'd0,5'd5,5'd5, 1,1,0,0, 0,0,0,0, 2'd3);
    vecs[3]  = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, 0,0,0,0, 2'd0);
    vecs[4]  = mk(1,0,1, 5'd0,5'd0,5'd0, 1,1,0,0, 0,0,0,0, 2'd0);
    vecs[5]  = mk(1,1,0, 5'd7,5'd0,5'd7, 1,1,0,0, 1,1,1,0, 2'd0);
    vecs[6]  = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, 0,0,0,0, 2'd3);
    vecs[7]  = mk(1,1,0, 5'd7,5'd0,5'd7, 1,0,0,0, 0,0,0,0, 2'd0);
    vecs[8]  = mk(0,1,0, 5'd7,5'd0,5'd7, 1,1,0,0, 0,0,0,0, 2'd0);
    vecs[9]  = mk(1,0,0, 5'd7,5'd7,5'd7, 1,1,0,0, 0,0,0,0, 2'd0);
    vecs[10] = mk(1,1,0, 5'd7,5'd0,5'd7, 0,1,0,0, 0,0,0,0, 2'd0);
    vecs[11] = mk(1,0,1, 5'd0,5'd9,5'd9, 1,1,1,1, 0,0,1,1, 2'd0);
    vecs[12] = mk(1,0,1, 5'd0,5'd9,5'd9, 1,1,1,1, 0,0,1,1, 2'd2);
    vecs[13] = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0, 1,1,0,0, 2'd0);
    vecs[14] = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,1,1, 1,1,0,0, 2'd1);
    vecs[15] = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, 0,0,0,0, 2'd1);
    vecs[16] = mk(0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, 0,0,0,0, 2'd0);

    idle();
    I_rst = 1'b0;
    I_ex_branch = 1'b1;
    I_ex_busy = 1'b1;
    #1;
    check_main("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("reset.count", {28'd0, cnt0}, 32'd0);
    @(negedge I_clk);
    @(negedge I_clk);
    idle();
    I_rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge I_clk);
      I_dec_valid = vecs[i].v; I_dec_useA = vecs[i].ua; I_dec_useB = vecs[i].ub;
      I_dec_selA = vecs[i].sa; I_dec_selB = vecs[i].sb; I_ex_selD = vecs[i].sd;
      I_ex_we = vecs[i].we; I_ex_isLoad = vecs[i].ld;
      I_ex_busy = vecs[i].busy; I_ex_branch = vecs[i].br;
      #1;
      check_main($sformatf("vec%0d", i), vecs[i].e_sf, vecs[i].e_sd,
                 vecs[i].e_bub, vecs[i].e_fl, vecs[i].e_st);
    end

    // Flush length for 1 and 3 flush cycles
    @(negedge I_clk);
    idle();
    I_ex_branch = 1'b1;
    #1;
    check("fl1.c0.flush", {31'd0, fl1}, 32'd1);
    check("fl3.c0.flush", {31'd0, fl3}, 32'd1);
    for (int c = 1; c < 5; c++) begin
      @(negedge I_clk);
      I_ex_branch = 1'b0;
      #1;
      check($sformatf("fl1.c%0d.flush", c), {31'd0, fl1}, 32'd0);
      check($sformatf("fl1.c%0d.state", c), {30'd0, st1}, 32'd0);
      check($sformatf("fl3.c%0d.flush", c), {31'd0, fl3}, (c < 3) ? 32'd1 : 32'd0);
      check($sformatf("fl3.c%0d.bubble", c), {31'd0, bub3}, (c < 3) ? 32'd1 : 32'd0);
      check($sformatf("fl3.c%0d.state", c), {30'd0, st3}, (c < 3) ? 32'd2 : 32'd0);
    end

    // Busy for 4 cycles from a cleared counter
    @(negedge I_clk);
    I_cnt_clr = 1'b1;
    @(negedge I_clk);
    I_cnt_clr = 1'b0;
    #1;
    check("clr.count", {28'd0, cnt0}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge I_clk);
      I_ex_busy = 1'b1;
      #1;
      check($sformatf("mc%0d.stall", c), {30'd0, sf0, sd0}, 32'd3);
      check($sformatf("mc%0d.bubble", c), {31'd0, bub0}, 32'd0);
    end
    @(negedge I_clk);
    I_ex_busy = 1'b0;
    #1;
    check("mc_end.stall", {30'd0, sf0, sd0}, 32'd0);
    check("mc_end.count", {28'd0, cnt0}, 32'd4);
    check("mc_end.count16", {16'd0, cnt1}, 32'd4);
    @(negedge I_clk);
    #1;
    check("mc_end.state", {30'd0, st0}, 32'd0);

    // 19 further stall cycles: 4-bit counter saturates, 16-bit one does not
    for (int c = 0; c < 19; c++) begin
      @(negedge I_clk);
      I_ex_busy = 1'b1;
    end
    @(negedge I_clk);
    I_ex_busy = 1'b0;
    #1;
    check("sat.count", {28'd0, cnt0}, 32'd15);
    check("sat.count16", {16'd0, cnt1}, 32'd23);

    // Reset asserted in the cycle after a branch aborts the flush
    @(negedge I_clk);
    I_ex_branch = 1'b1;
    @(negedge I_clk);
    I_ex_branch = 1'b0;
    #1;
    check("rst_fl.pre_state", {30'd0, st0}, 32'd2);
    I_rst = 1'b0;
    #1;
    check_main("rst_fl", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge I_clk);
    I_rst = 1'b1;
    #1;
    check_main("rst_fl.post", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("rst_fl.count", {28'd0, cnt0}, 32'd0);

    // Clear together with a stall wins over the increment
    for (int c = 0; c < 3; c++) begin
      @(negedge I_clk);
      I_ex_busy = 1'b1;
    end
    @(negedge I_clk);
    #1;
    check("clr_pre.count", {28'd0, cnt0}, 32'd3);
    I_cnt_clr = 1'b1;
    @(negedge I_clk);
    I_cnt_clr = 1'b0;
    I_ex_busy = 1'b0;
    #1;
    check("clr_stall.count", {28'd0, cnt0}, 32'd0);
    check("clr_stall.count16", {16'd0, cnt1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
